// File: rtl/conv_row_feeder_if.sv
// conv_row_feeder_if: load port, run control and layer-side stream bundle
interface conv_row_feeder_if #(
    parameter int max_input_matrix_width  = 9,
    parameter int max_input_matrix_height = 9,
    parameter int max_kernel_width        = 3,
    parameter int data_size               = 32
);
    logic                                               load_valid;
    logic                                               load_is_kernel;
    logic [$clog2(max_input_matrix_height)-1:0]         load_row;
    logic [data_size*max_input_matrix_width-1:0]        load_data;
    logic                                               load_ready;
    logic [$clog2(max_input_matrix_height+1)-1:0]       num_rows;
    logic                                               start;
    logic                                               busy;
    logic                                               done;
    logic                                               error;
    logic                                               enable;
    logic [data_size*max_input_matrix_width-1:0]        matrix_input_stream;
    logic [data_size*max_kernel_width-1:0]              kernel_input_stream;
    logic                                               out_row_valid;
    logic [$clog2(max_input_matrix_height)-1:0]         out_row_index;

    modport slave (
        input  load_valid, load_is_kernel, load_row, load_data, num_rows, start,
        output load_ready, busy, done, error, enable, matrix_input_stream,
               kernel_input_stream, out_row_valid, out_row_index
    );

    modport master (
        output load_valid, load_is_kernel, load_row, load_data, num_rows, start,
        input  load_ready, busy, done, error, enable, matrix_input_stream,
               kernel_input_stream, out_row_valid, out_row_index
    );
endinterface

// File: rtl/conv_row_feeder.sv
// conv_row_feeder: stores a matrix and kernel, then streams them into convolution_layer with aligned output-valid flags
module conv_row_feeder #(
    parameter int max_input_matrix_width  = 9,
    parameter int max_input_matrix_height = 9,
    parameter int max_kernel_width        = 3,
    parameter int max_kernel_height       = 3,
    parameter int data_size               = 32
) (
    input logic              clk,
    input logic              reset_n,
    conv_row_feeder_if.slave bus
);
    localparam int MW  = data_size * max_input_matrix_width;
    localparam int KBW = data_size * max_kernel_width;
    localparam int RW  = $clog2(max_input_matrix_height);
    localparam int NW  = $clog2(max_input_matrix_height + 1);
    localparam int KAW = (max_kernel_height > 1) ? $clog2(max_kernel_height) : 1;
    localparam logic [NW-1:0] KH_N  = NW'(max_kernel_height);
    localparam logic [NW-1:0] KH_M1 = NW'(max_kernel_height - 1);
    localparam logic [NW-1:0] H_N   = NW'(max_input_matrix_height);
    localparam logic [RW:0]   H_R   = (RW+1)'(max_input_matrix_height);
    localparam logic [RW:0]   KH_R  = (RW+1)'(max_kernel_height);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   k_q, k_d;
    logic [NW-1:0]   n_q, n_d;
    logic [MW-1:0]   mat_q [max_input_matrix_height];
    logic [KBW-1:0]  ker_q [max_kernel_height];
    logic            en_q, en_d;
    logic [MW-1:0]   mis_q, mis_d;
    logic [KBW-1:0]  kis_q, kis_d;
    logic            orv_q, orv_d;
    logic [RW-1:0]   ori_q, ori_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            idle, mat_wr, ker_wr, load_bad, start_ok, start_bad, feed;

    // Request decode: loads and starts are only considered in IDLE
    always_comb begin
        idle      = state_q == IDLE;
        mat_wr    = idle && bus.load_valid && !bus.load_is_kernel && {1'b0, bus.load_row} < H_R;
        ker_wr    = idle && bus.load_valid && bus.load_is_kernel && {1'b0, bus.load_row} < KH_R;
        load_bad  = idle && bus.load_valid && !mat_wr && !ker_wr;
        start_ok  = idle && bus.start && bus.num_rows >= KH_N && bus.num_rows <= H_N;
        start_bad = idle && bus.start && !start_ok;
    end

    // Next state plus the registered values the layer sees in the next cycle
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                state_d = start_ok ? PRIME : IDLE;
                n_d     = start_ok ? bus.num_rows : n_q;
            end
            PRIME: begin
                state_d = STREAM;
                k_d     = '0;
            end
            STREAM: begin
                state_d = (k_q == n_q - 1'b1) ? FLUSH : STREAM;
                k_d     = (k_q == n_q - 1'b1) ? k_q : k_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        feed   = state_d == STREAM;
        en_d   = state_d == PRIME || feed;
        mis_d  = feed ? mat_q[k_d[RW-1:0]] : '0;
        kis_d  = (feed && k_d < KH_N) ? ker_q[k_d[KAW-1:0]] : '0;
        orv_d  = state_q == STREAM && k_q >= KH_M1;
        ori_d  = orv_d ? RW'(k_q - KH_M1) : '0;
        done_d = state_q == FLUSH;
        err_d  = load_bad || start_bad;
    end

    // Control and stream output registers; reset abandons any run without a done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            en_q    <= 1'b0;
            mis_q   <= '0;
            kis_q   <= '0;
            orv_q   <= 1'b0;
            ori_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            en_q    <= en_d;
            mis_q   <= mis_d;
            kis_q   <= kis_d;
            orv_q   <= orv_d;
            ori_q   <= ori_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Row stores; a write accepted alongside start lands before the first stream read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mat_q <= '{default: '0};
            ker_q <= '{default: '0};
        end else begin
            if (mat_wr) mat_q[bus.load_row] <= bus.load_data;
            if (ker_wr) ker_q[bus.load_row[KAW-1:0]] <= bus.load_data[MW-1 -: KBW];
        end
    end

    assign bus.load_ready          = state_q == IDLE;
    assign bus.busy                = state_q != IDLE;
    assign bus.done                = done_q;
    assign bus.error               = err_q;
    assign bus.enable              = en_q;
    assign bus.matrix_input_stream = mis_q;
    assign bus.kernel_input_stream = kis_q;
    assign bus.out_row_valid       = orv_q;
    assign bus.out_row_index       = ori_q;
endmodule

// File: tb/tb_conv_row_feeder.sv
// tb_conv_row_feeder: randomized and directed runs checked cycle by cycle against a plan-based model
module tb_conv_row_feeder;
    localparam int DS = 32, W = 9, H = 9, KW = 3, KH = 3;
    localparam int MW = DS * W, KBW = DS * KW;

    typedef struct packed {
        logic           busy;
        logic           done;
        logic           error;
        logic           en;
        logic           orv;
        logic [3:0]     ori;
        logic [MW-1:0]  mis;
        logic [KBW-1:0] kis;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    conv_row_feeder_if #(.max_input_matrix_width(W), .max_input_matrix_height(H),
                         .max_kernel_width(KW), .data_size(DS)) bus ();

    conv_row_feeder #(.max_input_matrix_width(W), .max_input_matrix_height(H),
                      .max_kernel_width(KW), .max_kernel_height(KH), .data_size(DS))
        dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [MW-1:0]  mat_m [H];
    logic [KBW-1:0] ker_m [KH];
    exp_t           plan [$];
    exp_t           cur;
    bit             m_err;
    int             m_r;

    int             busy_cnt, done_cnt;
    int             idx_log [$];
    logic [MW-1:0]  cap_m [H];
    logic [KBW-1:0] cap_k [H];

    function automatic exp_t idle_rec();
        exp_t e;
        e = '0;
        return e;
    endfunction

    // A run is: one priming cycle, one cycle per row, one flush cycle, then the done cycle
    function automatic void build_plan(int n);
        exp_t e;
        e = idle_rec(); e.busy = 1; e.en = 1;
        plan.push_back(e);
        for (int k = 0; k < n; k++) begin
            e = idle_rec(); e.busy = 1; e.en = 1;
            e.mis = mat_m[k];
            e.kis = (k < KH) ? ker_m[k] : '0;
            e.orv = (k >= KH);
            e.ori = 4'(k - KH);
            plan.push_back(e);
        end
        e = idle_rec(); e.busy = 1;
        e.orv = 1; e.ori = 4'(n - KH);
        plan.push_back(e);
        e = idle_rec(); e.done = 1;
        plan.push_back(e);
    endfunction

    // Reference model: tracks stores and the expected outputs of the current cycle
    initial begin
        cur = idle_rec();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                foreach (mat_m[i]) mat_m[i] = '0;
                foreach (ker_m[i]) ker_m[i] = '0;
                plan.delete();
                cur = idle_rec();
            end else begin
                m_err = 0;
                if (!cur.busy) begin
                    m_r = int'(bus.load_row);
                    if (bus.load_valid) begin
                        if (bus.load_is_kernel && m_r < KH) ker_m[m_r] = bus.load_data[MW-1 -: KBW];
                        else if (!bus.load_is_kernel && m_r < H) mat_m[m_r] = bus.load_data;
                        else m_err = 1;
                    end
                    if (bus.start) begin
                        if (int'(bus.num_rows) >= KH && int'(bus.num_rows) <= H) build_plan(int'(bus.num_rows));
                        else m_err = 1;
                    end
                end
                cur = (plan.size() > 0) ? plan.pop_front() : idle_rec();
                cur.error = m_err;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    initial forever begin
        @(negedge clk);
        checks++;
        if (bus.busy !== cur.busy || bus.load_ready !== !cur.busy || bus.done !== cur.done ||
            bus.error !== cur.error || bus.enable !== cur.en || bus.out_row_valid !== cur.orv ||
            (cur.orv && bus.out_row_index !== cur.ori) ||
            bus.matrix_input_stream !== cur.mis || bus.kernel_input_stream !== cur.kis) begin
            errors++;
            $display("FAIL cycle t=%0t got busy=%b rdy=%b done=%b err=%b en=%b v=%b idx=%0d k=%h m=%h want busy=%b done=%b err=%b en=%b v=%b idx=%0d k=%h m=%h",
                     $time, bus.busy, bus.load_ready, bus.done, bus.error, bus.enable, bus.out_row_valid,
                     bus.out_row_index, bus.kernel_input_stream, bus.matrix_input_stream,
                     cur.busy, cur.done, cur.error, cur.en, cur.orv, cur.ori, cur.kis, cur.mis);
        end
    end

    // Observation of the DUT for run-level literal checks and layer-output reconstruction
    initial forever begin
        @(negedge clk);
        if (bus.busy) begin
            busy_cnt++;
            if (busy_cnt >= 2 && busy_cnt - 2 < H) begin
                cap_m[busy_cnt-2] = bus.matrix_input_stream;
                cap_k[busy_cnt-2] = bus.kernel_input_stream;
            end
        end
        if (bus.out_row_valid) idx_log.push_back(int'(bus.out_row_index));
        if (bus.done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        busy_cnt = 0;
        done_cnt = 0;
        idx_log.delete();
    endtask

    task automatic load(input bit isk, input int row, input logic [MW-1:0] d);
        bus.load_valid = 1; bus.load_is_kernel = isk; bus.load_row = 4'(row); bus.load_data = d;
        tick();
        bus.load_valid = 0;
    endtask

    task automatic start_run(input int n);
        bus.start = 1; bus.num_rows = 4'(n);
        tick();
        bus.start = 0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (cur.busy && b < 100) begin
            tick();
            b++;
        end
        if (cur.busy) chk("wait_idle_timeout", 1, 0);
    endtask

    function automatic logic [MW-1:0] row_rc(int r);
        logic [MW-1:0] v;
        for (int c = 0; c < W; c++) v[DS*(W-1-c) +: DS] = DS'(r + c);
        return v;
    endfunction

    function automatic logic [MW-1:0] krow(int a, int b, int c);
        logic [MW-1:0] v;
        v = '0;
        v[MW-1 -: KBW] = {DS'(a), DS'(b), DS'(c)};
        return v;
    endfunction

    function automatic logic [MW-1:0] rnd_row();
        logic [MW-1:0] v;
        for (int c = 0; c < W; c++) v[DS*c +: DS] = $urandom;
        return v;
    endfunction

    // First output row of the layer, rebuilt from the captured streamed rows
    function automatic int conv0(int j);
        int s;
        s = 0;
        for (int i = 0; i < KH; i++)
            for (int c = 0; c < KW; c++)
                s += int'(cap_m[i][DS*(W-1-(j+c)) +: DS]) * int'(cap_k[i][DS*(KW-1-c) +: DS]);
        return s;
    endfunction

    initial begin
        bus.load_valid = 0; bus.load_is_kernel = 0; bus.load_row = '0; bus.load_data = '0;
        bus.start = 0; bus.num_rows = '0;
        clear_mon();
        repeat (3) tick();
        chk("reset_load_ready", int'(bus.load_ready), 1);
        chk("reset_enable", int'(bus.enable), 0);
        reset_n = 1;
        tick();

        // single run: r+c matrix, all-ones kernel
        for (int r = 0; r < H; r++) load(0, r, row_rc(r));
        for (int r = 0; r < KH; r++) load(1, r, krow(1, 1, 1));
        clear_mon();
        start_run(9);
        wait_idle();
        tick();
        chk("single_busy_cycles", busy_cnt, 11);
        chk("single_done_pulses", done_cnt, 1);
        chk("single_valid_rows", idx_log.size(), 7);
        for (int i = 0; i < idx_log.size(); i++) chk("single_index", idx_log[i], i);
        for (int j = 0; j < 7; j++) chk("single_layer_row0", conv0(j), 18 + 9 * j);

        // minimum height with identity-centre kernel
        load(1, 0, krow(0, 0, 0));
        load(1, 1, krow(0, 1, 0));
        load(1, 2, krow(0, 0, 0));
        clear_mon();
        start_run(3);
        wait_idle();
        tick();
        chk("min_busy_cycles", busy_cnt, 5);
        chk("min_valid_rows", idx_log.size(), 1);
        if (idx_log.size() > 0) chk("min_index", idx_log[0], 0);
        for (int j = 0; j < 7; j++) chk("min_layer_row0", conv0(j), j + 2);

        // rejects, then a run showing the stores are intact
        start_run(2);
        tick();
        start_run(10);
        load(1, 3, krow(9, 9, 9));
        load(0, 9, rnd_row());
        tick();
        start_run(3);
        wait_idle();
        tick();

        // collision with start, and a dropped load during STREAM
        bus.load_valid = 1; bus.load_is_kernel = 0; bus.load_row = 4'd0; bus.load_data = rnd_row();
        bus.start = 1; bus.num_rows = 4'd4;
        tick();
        bus.load_valid = 0; bus.start = 0;
        tick();
        load(0, 1, rnd_row());
        wait_idle();
        tick();
        start_run(4);
        wait_idle();
        tick();

        // reset during STREAM k=4
        start_run(9);
        repeat (5) tick();
        clear_mon();
        #1 reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        repeat (3) tick();
        chk("reset_no_done", done_cnt, 0);
        chk("reset_no_busy", busy_cnt, 0);
        for (int r = 0; r < H; r++) load(0, r, rnd_row());
        for (int r = 0; r < KH; r++) load(1, r, rnd_row());
        start_run(6);
        wait_idle();
        tick();

        // back-to-back: second start lands in the done cycle
        clear_mon();
        start_run(5);
        wait_idle();
        start_run(5);
        wait_idle();
        tick();
        chk("b2b_done_pulses", done_cnt, 2);
        chk("b2b_busy_cycles", busy_cnt, 14);
        chk("b2b_valid_rows", idx_log.size(), 6);

        // randomized traffic, including ignored requests while busy
        repeat (40) begin
            case ($urandom_range(0, 3))
                0: load(0, $urandom_range(0, 11), rnd_row());
                1: load(1, $urandom_range(0, 4), rnd_row());
                2: begin
                    int b;
                    start_run($urandom_range(0, 11));
                    b = 0;
                    while (cur.busy && b < 40) begin
                        bus.load_valid = 1'($urandom_range(0, 1));
                        bus.load_is_kernel = 1'($urandom_range(0, 1));
                        bus.load_row = 4'($urandom_range(0, 8));
                        bus.load_data = rnd_row();
                        bus.start = 1'($urandom_range(0, 1));
                        bus.num_rows = 4'($urandom_range(3, 9));
                        tick();
                        b++;
                    end
                    bus.load_valid = 0; bus.start = 0;
                    if (cur.busy) chk("random_run_timeout", 1, 0);
                end
                default: repeat ($urandom_range(1, 3)) tick();
            endcase
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
